// File: rtl/quadrilatero_rf_read_arbiter_if.sv
// Request, register-file read port and row output bundle of the quadrilatero RF read arbiter.
// slave = arbiter side, master = requesters / register file / row consumer side.
interface quadrilatero_rf_read_arbiter_if #(
  parameter int unsigned N_REQ  = 3,
  parameter int unsigned N_REGS = 8,
  parameter int unsigned RLEN   = 128
);
  localparam int unsigned N_ROWS = RLEN / 32;
  localparam int unsigned REG_W  = (N_REGS > 1) ? $clog2(N_REGS) : 1;
  localparam int unsigned ROW_W  = (N_ROWS > 1) ? $clog2(N_ROWS) : 1;
  localparam int unsigned OWN_W  = $clog2(N_REQ);

  logic [N_REQ-1:0]             req_valid_i;
  logic [N_REQ-1:0][REG_W-1:0]  req_reg_i;
  logic [N_REQ-1:0]             req_ready_o;
  logic [REG_W-1:0]             rf_raddr_o;
  logic [ROW_W-1:0]             rf_rrowaddr_o;
  logic [RLEN-1:0]              rf_rdata_i;
  logic                         row_valid_o;
  logic                         row_ready_i;
  logic [RLEN-1:0]              row_data_o;
  logic [ROW_W-1:0]             row_idx_o;
  logic                         row_last_o;
  logic [OWN_W-1:0]             row_owner_o;
  logic                         busy_o;

  modport slave (
    input  req_valid_i, req_reg_i, rf_rdata_i, row_ready_i,
    output req_ready_o, rf_raddr_o, rf_rrowaddr_o, row_valid_o, row_data_o,
           row_idx_o, row_last_o, row_owner_o, busy_o
  );

  modport master (
    output req_valid_i, req_reg_i, rf_rdata_i, row_ready_i,
    input  req_ready_o, rf_raddr_o, rf_rrowaddr_o, row_valid_o, row_data_o,
           row_idx_o, row_last_o, row_owner_o, busy_o
  );
endinterface

// File: rtl/quadrilatero_rf_read_arbiter.sv
// Shares one matrix register-file read port between N_REQ requesters and streams the granted
// register row by row. Round-robin by default; QUADRILATERO_RF_ARB_FIXED_PRIO_EN selects fixed priority.
module quadrilatero_rf_read_arbiter #(
  parameter int unsigned N_REQ  = 3,
  parameter int unsigned N_REGS = 8,
  parameter int unsigned RLEN   = 128
) (
  input logic                           clk_i,
  input logic                           rst_ni,
  quadrilatero_rf_read_arbiter_if.slave bus
);
  localparam int unsigned N_ROWS = RLEN / 32;
  localparam int unsigned REG_W  = (N_REGS > 1) ? $clog2(N_REGS) : 1;
  localparam int unsigned ROW_W  = (N_ROWS > 1) ? $clog2(N_ROWS) : 1;
  localparam int unsigned OWN_W  = $clog2(N_REQ);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(N_ROWS - 1);

  typedef enum logic {IDLE, STREAM} state_e;

  state_e            state_q, state_d;
  logic [REG_W-1:0]  reg_q, reg_d;
  logic [OWN_W-1:0]  owner_q, owner_d;
  logic [ROW_W-1:0]  cnt_q, cnt_d;
  logic              done_q, done_d;
  logic              row_valid_q, row_valid_d;
  logic [RLEN-1:0]   row_data_q, row_data_d;
  logic [ROW_W-1:0]  row_idx_q, row_idx_d;
  logic              row_last_q, row_last_d;
  logic              busy_q, busy_d;
  logic [N_REQ-1:0]  req_ready_c;
  logic [OWN_W-1:0]  gnt_idx;
  logic              capture, handshake;

  // First valid requester at or after start, wrapping modulo N_REQ.
  function automatic logic [OWN_W-1:0] pick_first(input logic [N_REQ-1:0] v,
                                                   input logic [OWN_W-1:0] start);
    logic [OWN_W-1:0] pick;
    logic [OWN_W-1:0] sel;
    int unsigned      idx;
    pick = '0;
    for (int unsigned k = N_REQ; k > 0; k--) begin
      idx = (32'(start) + k - 1) % N_REQ;
      sel = OWN_W'(idx);
      if (v[sel]) pick = sel;
    end
    return pick;
  endfunction

`ifdef QUADRILATERO_RF_ARB_FIXED_PRIO_EN
  assign gnt_idx = pick_first(bus.req_valid_i, OWN_W'(0));
`else
  logic [OWN_W-1:0] ptr_q, ptr_d;
  assign gnt_idx = pick_first(bus.req_valid_i, ptr_q);
`endif

  assign handshake = row_valid_q & bus.row_ready_i;

  always_comb begin
    state_d     = state_q;
    reg_d       = reg_q;
    owner_d     = owner_q;
    cnt_d       = cnt_q;
    done_d      = done_q;
    row_valid_d = row_valid_q;
    row_data_d  = row_data_q;
    row_idx_d   = row_idx_q;
    row_last_d  = row_last_q;
    req_ready_c = '0;
    capture     = 1'b0;
`ifndef QUADRILATERO_RF_ARB_FIXED_PRIO_EN
    ptr_d       = ptr_q;
`endif
    case (state_q)
      IDLE: begin
        if (|bus.req_valid_i) begin
          req_ready_c[gnt_idx] = 1'b1;
          reg_d   = bus.req_reg_i[gnt_idx];
          owner_d = gnt_idx;
          cnt_d   = '0;
          done_d  = 1'b0;
          state_d = STREAM;
`ifndef QUADRILATERO_RF_ARB_FIXED_PRIO_EN
          ptr_d   = (gnt_idx == OWN_W'(N_REQ - 1)) ? '0 : gnt_idx + OWN_W'(1);
`endif
        end
      end
      STREAM: begin
        // Refill the output register whenever it is empty or being drained this cycle.
        capture = !done_q && (!row_valid_q || bus.row_ready_i);
        if (capture) begin
          row_data_d  = bus.rf_rdata_i;
          row_idx_d   = cnt_q;
          row_last_d  = (cnt_q == LAST_ROW);
          row_valid_d = 1'b1;
          if (cnt_q == LAST_ROW) done_d = 1'b1;
          else                   cnt_d  = cnt_q + ROW_W'(1);
        end else if (handshake) begin
          row_valid_d = 1'b0;
        end
        if (handshake && row_last_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE) || row_valid_d;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      reg_q       <= '0;
      owner_q     <= '0;
      cnt_q       <= '0;
      done_q      <= 1'b0;
      row_valid_q <= 1'b0;
      row_data_q  <= '0;
      row_idx_q   <= '0;
      row_last_q  <= 1'b0;
      busy_q      <= 1'b0;
`ifndef QUADRILATERO_RF_ARB_FIXED_PRIO_EN
      ptr_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      reg_q       <= reg_d;
      owner_q     <= owner_d;
      cnt_q       <= cnt_d;
      done_q      <= done_d;
      row_valid_q <= row_valid_d;
      row_data_q  <= row_data_d;
      row_idx_q   <= row_idx_d;
      row_last_q  <= row_last_d;
      busy_q      <= busy_d;
`ifndef QUADRILATERO_RF_ARB_FIXED_PRIO_EN
      ptr_q       <= ptr_d;
`endif
    end
  end

  assign bus.req_ready_o   = req_ready_c;
  assign bus.rf_raddr_o    = reg_q;
  assign bus.rf_rrowaddr_o = cnt_q;
  assign bus.row_valid_o   = row_valid_q;
  assign bus.row_data_o    = row_data_q;
  assign bus.row_idx_o     = row_idx_q;
  assign bus.row_last_o    = row_last_q;
  assign bus.row_owner_o   = owner_q;
  assign bus.busy_o        = busy_q;
endmodule

// File: tb/tb_quadrilatero_rf_read_arbiter.sv
// Scoreboard bench for quadrilatero_rf_read_arbiter: expected rows are queued at grant time and
// a negedge monitor pops and compares them on every row handshake.
module tb_quadrilatero_rf_read_arbiter;
  localparam int unsigned N_REQ  = 3;
  localparam int unsigned N_REGS = 8;
  localparam int unsigned RLEN   = 128;
  localparam int unsigned N_ROWS = 4;

  typedef struct {
    logic [1:0]   owner;
    logic [1:0]   idx;
    logic         last;
    logic [127:0] data;
  } row_t;

  logic clk_i = 1'b0;
  logic rst_ni = 1'b0;
  always #5 clk_i = ~clk_i;

  quadrilatero_rf_read_arbiter_if #(.N_REQ(N_REQ), .N_REGS(N_REGS), .RLEN(RLEN)) bus ();

  quadrilatero_rf_read_arbiter #(.N_REQ(N_REQ), .N_REGS(N_REGS), .RLEN(RLEN)) dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .bus    (bus)
  );

  // Register file model: row r of register k holds {4{k*16+r}}.
  logic [31:0] rf_word;
  assign rf_word = 32'(bus.rf_raddr_o) * 32'd16 + 32'(bus.rf_rrowaddr_o);
  assign bus.rf_rdata_i = {4{rf_word}};

  int   checks   = 0;
  int   failures = 0;
  row_t sb_q[$];
  row_t mon_e;
  logic pat_en = 1'b0;
  int unsigned pat_cnt = 0;

  function automatic logic [127:0] exp_row(input logic [2:0] k, input int unsigned r);
    logic [31:0] w;
    w = 32'(k) * 32'd16 + 32'(r);
    return {4{w}};
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic samp();
    @(negedge clk_i);
  endtask

  task automatic drive_pat();
    if (pat_en) begin
      pat_cnt++;
      bus.row_ready_i = ((pat_cnt % 3) != 2);
    end
  endtask

  task automatic push_reg(input logic [1:0] own, input logic [2:0] k);
    row_t e;
    for (int r = 0; r < int'(N_ROWS); r++) begin
      e.owner = own;
      e.idx   = 2'(r);
      e.last  = (r == int'(N_ROWS) - 1);
      e.data  = exp_row(k, 32'(r));
      sb_q.push_back(e);
    end
  endtask

  task automatic wait_idle(input string name, input int unsigned budget);
    int unsigned n;
    n = 0;
    do begin
      tick();
      drive_pat();
      samp();
      n++;
    end while ((bus.busy_o !== 1'b0 || sb_q.size() != 0) && n < budget);
    if (bus.busy_o !== 1'b0 || sb_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout: busy=%0b pending_rows=%0d, required idle with 0 pending",
               name, bus.busy_o, sb_q.size());
    end
  endtask

  task automatic do_read(input logic [1:0] r, input logic [2:0] k);
    int unsigned n;
    tick();
    bus.req_reg_i[r]   = k;
    bus.req_valid_i[r] = 1'b1;
    drive_pat();
    samp();
    n = 0;
    while (bus.req_ready_o[r] !== 1'b1 && n < 20) begin
      tick();
      drive_pat();
      samp();
      n++;
    end
    chk("rd_gnt", 128'(bus.req_ready_o), 128'(3'(3'b001 << r)));
    push_reg(r, k);
    tick();
    bus.req_valid_i[r] = 1'b0;
    drive_pat();
    samp();
    wait_idle("rd", 40);
  endtask

  // Scoreboard monitor: every row handshake must match the oldest expected row.
  always @(negedge clk_i) begin
    if (rst_ni && bus.row_valid_o && bus.row_ready_i) begin
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_unexpected: got row owner %0d idx %0d, expected no row",
                 bus.row_owner_o, bus.row_idx_o);
      end else begin
        mon_e = sb_q.pop_front();
        chk("sb_owner", 128'(bus.row_owner_o), 128'(mon_e.owner));
        chk("sb_idx",   128'(bus.row_idx_o),   128'(mon_e.idx));
        chk("sb_last",  128'(bus.row_last_o),  128'(mon_e.last));
        chk("sb_data",  bus.row_data_o,        mon_e.data);
      end
    end
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned exp_order [5];
    int unsigned g;
    int unsigned n;
    int unsigned last_t;

    bus.req_valid_i = '0;
    bus.req_reg_i   = '0;
    bus.row_ready_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1 rst_ni = 1'b1;
    samp();

    // Reset state
    chk("rst_req_ready", 128'(bus.req_ready_o),   128'(0));
    chk("rst_raddr",     128'(bus.rf_raddr_o),    128'(0));
    chk("rst_rrowaddr",  128'(bus.rf_rrowaddr_o), 128'(0));
    chk("rst_row_valid", 128'(bus.row_valid_o),   128'(0));
    chk("rst_row_data",  bus.row_data_o,          128'(0));
    chk("rst_row_idx",   128'(bus.row_idx_o),     128'(0));
    chk("rst_row_last",  128'(bus.row_last_o),    128'(0));
    chk("rst_owner",     128'(bus.row_owner_o),   128'(0));
    chk("rst_busy",      128'(bus.busy_o),        128'(0));

    // Back-to-back: req 0 (reg 6) then req 2 (reg 1)
    tick();
    bus.row_ready_i  = 1'b1;
    bus.req_reg_i[0] = 3'd6;
    bus.req_reg_i[2] = 3'd1;
    bus.req_valid_i  = 3'b101;
    samp();
    chk("b2b_gnt0", 128'(bus.req_ready_o), 128'(3'b001));
    push_reg(2'd0, 3'd6);
    tick();
    bus.req_valid_i[0] = 1'b0;
    samp();
    for (int c = 1; c < 6; c++) begin
      if (c > 1) begin
        tick();
        samp();
      end
      chk("b2b_no_gnt", 128'(bus.req_ready_o), 128'(0));
    end
    tick();
    samp();
    chk("b2b_gnt2",   128'(bus.req_ready_o), 128'(3'b100));
    chk("b2b_bubble", 128'(bus.row_valid_o), 128'(0));
    push_reg(2'd2, 3'd1);
    tick();
    bus.req_valid_i = '0;
    samp();
    chk("b2b_t1_invalid", 128'(bus.row_valid_o), 128'(0));
    tick();
    samp();
    chk("b2b_row0_valid", 128'(bus.row_valid_o), 128'(1));
    chk("b2b_row0_owner", 128'(bus.row_owner_o), 128'(2));
    chk("b2b_row0_idx",   128'(bus.row_idx_o),   128'(0));
    wait_idle("b2b", 20);

    // Single request: req 1, reg 5, consumer always ready
    tick();
    bus.req_reg_i[1] = 3'd5;
    bus.req_valid_i  = 3'b010;
    samp();
    chk("single_gnt", 128'(bus.req_ready_o), 128'(3'b010));
    push_reg(2'd1, 3'd5);
    tick();
    bus.req_valid_i = '0;
    samp();
    chk("single_raddr",      128'(bus.rf_raddr_o),  128'(5));
    chk("single_t1_invalid", 128'(bus.row_valid_o), 128'(0));
    for (int r = 0; r < 4; r++) begin
      tick();
      samp();
      chk("single_valid", 128'(bus.row_valid_o), 128'(1));
      chk("single_idx",   128'(bus.row_idx_o),   128'(r));
      chk("single_owner", 128'(bus.row_owner_o), 128'(1));
      chk("single_last",  128'(bus.row_last_o),  128'(r == 3));
    end
    tick();
    samp();
    chk("single_busy_done",  128'(bus.busy_o),        128'(0));
    chk("single_valid_done", 128'(bus.row_valid_o),   128'(0));
    chk("single_raddr_hold", 128'(bus.rf_raddr_o),    128'(5));
    chk("single_row_hold",   128'(bus.rf_rrowaddr_o), 128'(3));

    // Backpressure: req 2, reg 3, stall 3 cycles once row 1 is presented
    tick();
    bus.req_reg_i[2] = 3'd3;
    bus.req_valid_i  = 3'b100;
    samp();
    chk("bp_gnt", 128'(bus.req_ready_o), 128'(3'b100));
    push_reg(2'd2, 3'd3);
    tick();
    bus.req_valid_i = '0;
    samp();
    tick();
    samp();
    chk("bp_row0_idx", 128'(bus.row_idx_o), 128'(0));
    tick();
    bus.row_ready_i = 1'b0;
    samp();
    for (int c = 0; c < 3; c++) begin
      if (c > 0) begin
        tick();
        samp();
      end
      chk("bp_hold_valid", 128'(bus.row_valid_o),   128'(1));
      chk("bp_hold_idx",   128'(bus.row_idx_o),     128'(1));
      chk("bp_hold_data",  bus.row_data_o,          exp_row(3'd3, 1));
      chk("bp_rowaddr",    128'(bus.rf_rrowaddr_o), 128'(2));
    end
    tick();
    bus.row_ready_i = 1'b1;
    samp();
    chk("bp_release_idx", 128'(bus.row_idx_o), 128'(1));
    wait_idle("bp", 20);

    // Data integrity: every register, ready pattern with periodic stalls
    pat_en = 1'b1;
    for (int k = 0; k < int'(N_REGS); k++) begin
      do_read(2'(k % 3), 3'(k));
    end
    pat_en = 1'b0;
    tick();
    bus.row_ready_i = 1'b1;
    samp();

    // Reset mid-stream: req 1, reg 4
    tick();
    bus.req_reg_i[1] = 3'd4;
    bus.req_valid_i  = 3'b010;
    samp();
    chk("mrst_gnt", 128'(bus.req_ready_o), 128'(3'b010));
    push_reg(2'd1, 3'd4);
    tick();
    bus.req_valid_i = '0;
    samp();
    repeat (3) begin
      tick();
      samp();
    end
    chk("mrst_row2_idx", 128'(bus.row_idx_o), 128'(2));
    tick();
    rst_ni = 1'b0;
    sb_q.delete();
    samp();
    chk("mrst_valid", 128'(bus.row_valid_o), 128'(0));
    chk("mrst_busy",  128'(bus.busy_o),      128'(0));
    tick();
    samp();
    tick();
    rst_ni = 1'b1;
    samp();
    chk("mrst_busy_after", 128'(bus.busy_o), 128'(0));

    // Contention: all requesters held high
`ifdef QUADRILATERO_RF_ARB_FIXED_PRIO_EN
    exp_order = '{0, 0, 0, 0, 0};
`else
    exp_order = '{0, 1, 2, 0, 1};
`endif
    tick();
    bus.req_reg_i[0] = 3'd1;
    bus.req_reg_i[1] = 3'd2;
    bus.req_reg_i[2] = 3'd3;
    bus.req_valid_i  = 3'b111;
    samp();
    g = 0;
    n = 0;
    last_t = 0;
    while (g < 5 && n < 60) begin
      if (bus.req_ready_o != '0) begin
        chk("cont_gnt", 128'(bus.req_ready_o), 128'(3'(3'b001 << exp_order[g])));
        if (g > 0) chk("cont_gap", 128'(n - last_t), 128'(6));
        push_reg(2'(exp_order[g]), 3'(exp_order[g] + 1));
        last_t = n;
        g++;
      end
      if (g < 5) begin
        tick();
        samp();
        n++;
      end
    end
    if (g < 5) begin
      checks++;
      failures++;
      $display("FAIL cont_timeout: got %0d grants, expected 5", g);
    end
    tick();
    bus.req_valid_i = '0;
    samp();
    wait_idle("cont", 20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
